mmio_fifo_ctrl: RTL and testbench
=================================

# mmio_fifo_ctrl

MMIO-sequenced FIFO controller for the CCI-P AFU. Decodes host MMIO writes and reads into push, pop, status and control operations on a circular-buffer FIFO. Returns read responses with the host's TID. Tracks occupancy and sticky overflow/underflow errors. Sits between the AFU's MMIO header decode (rx.c0) and the tx.c2 read-response path.

## Interface
Parameters:
- DEPTH, 8, FIFO entries; power of two, at least 2
- WIDTH, 64, data width in bits
- DATA_ADDR, 16'h0020, push (write) and pop (read) address
- STAT_ADDR, 16'h0022, status register address (read-only)
- CTRL_ADDR, 16'h0024, control register address (write-only; reads return 0)

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- mmio_wr_valid  in  1  MMIO write strobe, one cycle per request
- mmio_rd_valid  in  1  MMIO read strobe, one cycle per request
- mmio_addr  in  16  MMIO word address
- mmio_tid  in  9  transaction ID of the read request
- mmio_wdata  in  WIDTH  write data
- rsp_valid  out  1  read response strobe
- rsp_tid  out  9  echoed TID
- rsp_data  out  WIDTH  response data
- fifo_full  out  1  count == DEPTH
- fifo_empty  out  1  count == 0
- fifo_count  out  $clog2(DEPTH)+1  occupancy
- irq_err  out  1  OR of the two sticky error bits

## Operation
- State: wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrap naturally modulo DEPTH; count; sticky bits ovf and udf.
- All decisions use pre-cycle state. The order within a cycle is pop, then push, then control.
- Write to DATA_ADDR:
  - If not full, or a pop occurs in the same cycle: store at wr_ptr, increment wr_ptr.
  - Otherwise: drop the data and set ovf.
- Read of DATA_ADDR:
  - If not empty: respond with the entry at rd_ptr and increment rd_ptr (pop).
  - If empty: respond with 0 and set udf. Pointers are unchanged.
- Read of STAT_ADDR: response = {zeros, count in [15:8], 4'b0, udf[3], ovf[2], full[1], empty[0]}. Reads have no side effects.
- Write to CTRL_ADDR:
  - bit0 = flush: pointers and count go to 0. Flush overrides a push or pop in the same cycle.
  - bit1 = clear sticky errors. Clearing has priority over a set in the same cycle.
- Read of any other address returns 0. Write to any other address is ignored.
- Simultaneous push and pop: both execute; count is unchanged.
  - When empty, the pop underflows and the push succeeds (count becomes 1).
  - When full, both succeed.
- count update = count + push_ok - pop_ok. It never exceeds DEPTH and never goes below 0.

## Timing
- Reset values:
  - rsp_valid 0, rsp_tid 0, rsp_data 0.
  - fifo_full 0, fifo_empty 1, fifo_count 0, irq_err 0.
  - Pointers, ovf and udf are 0.
- Read latency is 1 cycle: a request in cycle N gives rsp_valid = 1 in cycle N+1 for exactly one cycle, with rsp_tid and rsp_data.
- Back-to-back reads give back-to-back responses. There is no backpressure.
- rsp_data and rsp_tid hold their last value when rsp_valid = 0.
- fifo_full, fifo_empty, fifo_count and irq_err are registered. They reflect an operation in cycle N from cycle N+1.
- A status read in the same cycle as a push or pop returns the pre-operation values.
- Reset asserted mid-operation clears all state immediately. A pending response is lost (rsp_valid forced to 0).

## Structure
- Package mmio_fifo_pkg contains:
  - the default address constants;
  - the status bit positions (ST_EMPTY=0, ST_FULL=1, ST_OVF=2, ST_UDF=3, ST_CNT_LSB=8);
  - the control bit positions (CT_FLUSH=0, CT_CLR=1).
- Sub-module fifo_storage: a DEPTH×WIDTH register array with a write port (we, waddr, wdata) and a combinational read port (raddr, rdata). It has no reset on the data array.
- The controller owns the pointers, count, error bits, decode and response register.

## Test plan
- Reset, then write 64'hA, 64'hB, 64'hC to 0x0020, then read 0x0020 three times with TIDs 1, 2, 3 → responses A, B, C with TIDs 1, 2, 3, each 1 cycle after its request; fifo_empty = 1 afterwards.
- Push 9 values 1..9 with DEPTH = 8 → fifo_full = 1, count = 8, value 9 dropped, irq_err = 1; status read returns 64'h0806; 8 pops return 1..8.
- Read 0x0020 when empty → rsp_data = 0, udf set, status = 64'h0009; then write 64'h2 to 0x0024 → status = 64'h0001, irq_err = 0.
- Wrap-around: push/pop pairs 20 times with data i → each pop returns the matching i; pointers wrap without error.
- Full FIFO, push 64'h55 and pop in the same cycle → response is the oldest entry; count stays 8; 64'h55 is later popped last; no ovf.
- Push 3 entries, write 64'h1 to 0x0024 → count = 0, empty = 1; next pop underflows. Also assert rst between a read request and its response → no rsp_valid; all outputs return to their reset values.

Source files
------------

// File: rtl/mmio_fifo_ctrl_pkg.sv
// Shared constants for the MMIO-sequenced FIFO controller: default register addresses
// and the bit positions of the status and control registers.
package mmio_fifo_pkg;

  localparam logic [15:0] DEF_DATA_ADDR = 16'h0020;
  localparam logic [15:0] DEF_STAT_ADDR = 16'h0022;
  localparam logic [15:0] DEF_CTRL_ADDR = 16'h0024;

  localparam int unsigned ST_EMPTY   = 0;
  localparam int unsigned ST_FULL    = 1;
  localparam int unsigned ST_OVF     = 2;
  localparam int unsigned ST_UDF     = 3;
  localparam int unsigned ST_CNT_LSB = 8;

  localparam int unsigned CT_FLUSH = 0;
  localparam int unsigned CT_CLR   = 1;

endpackage

// File: rtl/mmio_fifo_ctrl_if.sv
// MMIO request / read-response / status bundle between the host decode and the FIFO controller.
interface mmio_fifo_ctrl_if #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 64
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic             mmio_wr_valid;
  logic             mmio_rd_valid;
  logic [15:0]      mmio_addr;
  logic [8:0]       mmio_tid;
  logic [WIDTH-1:0] mmio_wdata;
  logic             rsp_valid;
  logic [8:0]       rsp_tid;
  logic [WIDTH-1:0] rsp_data;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic             irq_err;

  modport master (
    output mmio_wr_valid, mmio_rd_valid, mmio_addr, mmio_tid, mmio_wdata,
    input  rsp_valid, rsp_tid, rsp_data, fifo_full, fifo_empty, fifo_count, irq_err
  );

  modport slave (
    input  mmio_wr_valid, mmio_rd_valid, mmio_addr, mmio_tid, mmio_wdata,
    output rsp_valid, rsp_tid, rsp_data, fifo_full, fifo_empty, fifo_count, irq_err
  );

endinterface

// File: rtl/mmio_fifo_ctrl_storage.sv
// DEPTH x WIDTH register array: one synchronous write port, one combinational read port.
module fifo_storage #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Data array is deliberately unreset; occupancy tracking guards every read.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mmio_fifo_ctrl.sv
// MMIO-decoded circular FIFO: push/pop via DATA_ADDR, status and control registers,
// one-cycle read responses echoing the host TID, sticky overflow/underflow errors.
module mmio_fifo_ctrl
  import mmio_fifo_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned WIDTH     = 64,
  parameter logic [15:0] DATA_ADDR = DEF_DATA_ADDR,
  parameter logic [15:0] STAT_ADDR = DEF_STAT_ADDR,
  parameter logic [15:0] CTRL_ADDR = DEF_CTRL_ADDR
) (
  input  logic             clk,
  input  logic             rst,
  mmio_fifo_ctrl_if.slave  io_mmio
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_ovf, r_udf;
  logic             r_rsp_valid;
  logic [8:0]       r_rsp_tid;
  logic [WIDTH-1:0] r_rsp_data;

  logic             w_empty, w_full;
  logic             w_data_wr, w_data_rd, w_stat_rd, w_ctrl_wr;
  logic             w_pop, w_push, w_ovf_set, w_udf_set, w_flush, w_clr;
  logic [WIDTH-1:0] w_rdata, w_stat, w_rsp_data;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));

  assign w_data_wr = io_mmio.mmio_wr_valid && (io_mmio.mmio_addr == DATA_ADDR);
  assign w_ctrl_wr = io_mmio.mmio_wr_valid && (io_mmio.mmio_addr == CTRL_ADDR);
  assign w_data_rd = io_mmio.mmio_rd_valid && (io_mmio.mmio_addr == DATA_ADDR);
  assign w_stat_rd = io_mmio.mmio_rd_valid && (io_mmio.mmio_addr == STAT_ADDR);

  // Pop is evaluated first, so a push into a full FIFO succeeds when a pop frees a slot.
  assign w_pop     = w_data_rd && !w_empty;
  assign w_udf_set = w_data_rd && w_empty;
  assign w_push    = w_data_wr && (!w_full || w_pop);
  assign w_ovf_set = w_data_wr && w_full && !w_pop;
  assign w_flush   = w_ctrl_wr && io_mmio.mmio_wdata[CT_FLUSH];
  assign w_clr     = w_ctrl_wr && io_mmio.mmio_wdata[CT_CLR];

  fifo_storage #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_storage (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (io_mmio.mmio_wdata),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  always_comb begin
    w_stat                     = '0;
    w_stat[ST_EMPTY]           = w_empty;
    w_stat[ST_FULL]            = w_full;
    w_stat[ST_OVF]             = r_ovf;
    w_stat[ST_UDF]             = r_udf;
    w_stat[ST_CNT_LSB +: CW]   = r_count;
  end

  always_comb begin
    w_rsp_data = '0;
    if (w_pop)          w_rsp_data = w_rdata;
    else if (w_stat_rd) w_rsp_data = w_stat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
      r_ovf <= w_clr ? 1'b0 : (r_ovf | w_ovf_set);
      r_udf <= w_clr ? 1'b0 : (r_udf | w_udf_set);
    end
  end

  // Response payload holds between reads; only the strobe is per-cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_tid   <= '0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= io_mmio.mmio_rd_valid;
      if (io_mmio.mmio_rd_valid) begin
        r_rsp_tid  <= io_mmio.mmio_tid;
        r_rsp_data <= w_rsp_data;
      end
    end
  end

  assign io_mmio.rsp_valid  = r_rsp_valid;
  assign io_mmio.rsp_tid    = r_rsp_tid;
  assign io_mmio.rsp_data   = r_rsp_data;
  assign io_mmio.fifo_full  = w_full;
  assign io_mmio.fifo_empty = w_empty;
  assign io_mmio.fifo_count = r_count;
  assign io_mmio.irq_err    = r_ovf | r_udf;

endmodule

// File: tb/tb_mmio_fifo_ctrl.sv
// Directed bench for mmio_fifo_ctrl (DEPTH=8, WIDTH=64) with hand-computed expectations.
module tb_mmio_fifo_ctrl;

  localparam logic [15:0] A_DATA = 16'h0020;
  localparam logic [15:0] A_STAT = 16'h0022;
  localparam logic [15:0] A_CTRL = 16'h0024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_total = 0;
  int   n_bad   = 0;

  mmio_fifo_ctrl_if #(.DEPTH(8), .WIDTH(64)) u_if ();

  mmio_fifo_ctrl #(
    .DEPTH (8),
    .WIDTH (64)
  ) u_dut (
    .clk     (clk),
    .rst     (rst),
    .io_mmio (u_if.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] addr, input logic [63:0] data);
    u_if.mmio_wr_valid = 1'b1;
    u_if.mmio_addr     = addr;
    u_if.mmio_wdata    = data;
    cyc();
    u_if.mmio_wr_valid = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [15:0] addr, input logic [8:0] tid,
                    input logic [63:0] exp);
    u_if.mmio_rd_valid = 1'b1;
    u_if.mmio_addr     = addr;
    u_if.mmio_tid      = tid;
    cyc();
    u_if.mmio_rd_valid = 1'b0;
    chk({tag, ".vld"}, 64'(u_if.rsp_valid), 64'd1);
    chk({tag, ".tid"}, 64'(u_if.rsp_tid), 64'(tid));
    chk({tag, ".data"}, u_if.rsp_data, exp);
  endtask

  task automatic chk_flags(input string tag, input int cnt, input logic full,
                           input logic empty, input logic irq);
    chk({tag, ".cnt"}, 64'(u_if.fifo_count), 64'(cnt));
    chk({tag, ".full"}, 64'(u_if.fifo_full), 64'(full));
    chk({tag, ".empty"}, 64'(u_if.fifo_empty), 64'(empty));
    chk({tag, ".irq"}, 64'(u_if.irq_err), 64'(irq));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    u_if.mmio_wr_valid = 1'b0;
    u_if.mmio_rd_valid = 1'b0;
    u_if.mmio_addr     = '0;
    u_if.mmio_tid      = '0;
    u_if.mmio_wdata    = '0;

    // Reset values
    #3;
    chk("rst.vld", 64'(u_if.rsp_valid), 64'd0);
    chk("rst.tid", 64'(u_if.rsp_tid), 64'd0);
    chk("rst.data", u_if.rsp_data, 64'd0);
    chk_flags("rst", 0, 1'b0, 1'b1, 1'b0);
    cyc();
    cyc();
    rst = 1'b0;
    cyc();

    // Basic push/pop ordering with TID echo
    wr(A_DATA, 64'hA);
    wr(A_DATA, 64'hB);
    wr(A_DATA, 64'hC);
    chk_flags("abc", 3, 1'b0, 1'b0, 1'b0);
    rd("popA", A_DATA, 9'd1, 64'hA);
    rd("popB", A_DATA, 9'd2, 64'hB);
    rd("popC", A_DATA, 9'd3, 64'hC);
    chk_flags("abc.done", 0, 1'b0, 1'b1, 1'b0);
    cyc();
    chk("hold.vld", 64'(u_if.rsp_valid), 64'd0);
    chk("hold.data", u_if.rsp_data, 64'hC);
    chk("hold.tid", 64'(u_if.rsp_tid), 64'd3);

    // Overflow: 9 pushes into 8 entries
    for (int i = 1; i <= 9; i++) wr(A_DATA, 64'(i));
    chk_flags("ovf", 8, 1'b1, 1'b0, 1'b1);
    rd("ovf.stat", A_STAT, 9'h1F, 64'h0806);
    for (int i = 1; i <= 8; i++) rd($sformatf("ovf.pop%0d", i), A_DATA, 9'(i), 64'(i));
    chk_flags("ovf.drain", 0, 1'b0, 1'b1, 1'b1);
    wr(A_CTRL, 64'h2);
    chk_flags("ovf.clr", 0, 1'b0, 1'b1, 1'b0);

    // Underflow and clear; other addresses read 0
    rd("udf.pop", A_DATA, 9'h100, 64'd0);
    rd("udf.stat", A_STAT, 9'd4, 64'h0009);
    chk("udf.irq", 64'(u_if.irq_err), 64'd1);
    wr(A_CTRL, 64'h2);
    rd("clr.stat", A_STAT, 9'd5, 64'h0001);
    chk("clr.irq", 64'(u_if.irq_err), 64'd0);
    rd("ctrl.rd", A_CTRL, 9'd6, 64'd0);
    wr(16'h0030, 64'hDEAD);
    chk_flags("bad.wr", 0, 1'b0, 1'b1, 1'b0);

    // Wrap-around over 20 push/pop pairs
    for (int i = 0; i < 20; i++) begin
      wr(A_DATA, 64'(i) + 64'h100);
      rd($sformatf("wrap%0d", i), A_DATA, 9'(i), 64'(i) + 64'h100);
    end
    chk_flags("wrap", 0, 1'b0, 1'b1, 1'b0);

    // Simultaneous push and pop on a full FIFO
    for (int i = 0; i < 8; i++) wr(A_DATA, 64'h10 + 64'(i));
    chk_flags("full", 8, 1'b1, 1'b0, 1'b0);
    u_if.mmio_wdata = 64'h55;
    u_if.mmio_wr_valid = 1'b1;
    rd("both", A_DATA, 9'd7, 64'h10);
    u_if.mmio_wr_valid = 1'b0;
    chk_flags("both", 8, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i < 8; i++) rd($sformatf("both.pop%0d", i), A_DATA, 9'(i), 64'h10 + 64'(i));
    rd("both.last", A_DATA, 9'd8, 64'h55);
    chk_flags("both.drain", 0, 1'b0, 1'b1, 1'b0);

    // Flush, then the next pop underflows
    wr(A_DATA, 64'h1);
    wr(A_DATA, 64'h2);
    wr(A_DATA, 64'h3);
    chk_flags("pre.flush", 3, 1'b0, 1'b0, 1'b0);
    wr(A_CTRL, 64'h1);
    chk_flags("flush", 0, 1'b0, 1'b1, 1'b0);
    rd("flush.pop", A_DATA, 9'd9, 64'd0);
    chk_flags("flush.udf", 0, 1'b0, 1'b1, 1'b1);

    // Reset between a read request and its response
    wr(A_DATA, 64'h77);
    chk_flags("pre.rst", 1, 1'b0, 1'b0, 1'b1);
    u_if.mmio_rd_valid = 1'b1;
    u_if.mmio_addr     = A_STAT;
    u_if.mmio_tid      = 9'd12;
    #2;
    rst = 1'b1;
    #1;
    u_if.mmio_rd_valid = 1'b0;
    cyc();
    chk("mid.vld", 64'(u_if.rsp_valid), 64'd0);
    chk("mid.tid", 64'(u_if.rsp_tid), 64'd0);
    chk("mid.data", u_if.rsp_data, 64'd0);
    chk_flags("mid", 0, 1'b0, 1'b1, 1'b0);
    rst = 1'b0;
    cyc();
    rd("post.stat", A_STAT, 9'd13, 64'h0001);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
